multi_servo_sweeper: RTL and testbench

Parametrised N-channel successor to the single-servo sweep FSM in the dispenser datapath. It drives NUM_CH hobby servos from one shared 20 ms PWM frame. Each channel independently runs a programmable number of 0°→max→0° dispense sweeps with pauses at both endpoints. New relative to the single-channel unit:
- channel addressing,
- start rejection reporting,
- per-channel abort with controlled return to 0°,
- saturating sweep arithmetic,
- latched turn count,
- a completion pulse.

---
 rtl/multi_servo_sweeper_if.sv | 27 ++
 rtl/multi_servo_sweeper.sv | 209 ++++++++++++++++++++
 tb/tb_multi_servo_sweeper.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_servo_sweeper_if.sv
// Control and status bundle for multi_servo_sweeper: job requests and aborts in,
// per-channel PWM plus busy/done and a shared reject pulse out.
interface multi_servo_sweeper_if #(
  parameter int NUM_CH = 4,
  parameter int TURN_W = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              start;
  logic [CH_W-1:0]   ch_sel;
  logic [TURN_W-1:0] num_turns;
  logic [NUM_CH-1:0] abort;
  logic [NUM_CH-1:0] pwm_out;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;
  logic              err;

  modport master (
    output start, ch_sel, num_turns, abort,
    input  pwm_out, busy, done, err
  );

  modport slave (
    input  start, ch_sel, num_turns, abort,
    output pwm_out, busy, done, err
  );
endinterface

// File: rtl/multi_servo_sweeper.sv
// N-channel servo sweeper: one shared PWM frame, per-channel sweep FSMs that run
// a latched number of 0->max->0 sweeps, with abort-to-zero and start rejection.
module multi_servo_sweeper #(
  parameter int NUM_CH    = 4,
  parameter int FRAME_CYC = 2_500_000,
  parameter int MIN_PULSE = 62_500,
  parameter int MAX_PULSE = 305_555,
  parameter int STEP      = 3000,
  parameter int PAUSE_CYC = 62_500_000,
  parameter int TURN_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_servo_sweeper_if.slave  bus
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(FRAME_CYC);
  localparam int WAIT_W = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;

  localparam logic [CNT_W-1:0]  MIN_PW     = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0]  MAX_PW     = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(PAUSE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAUSE_LOW,
    S_SWEEP_UP,
    S_PAUSE_HIGH,
    S_SWEEP_DOWN,
    S_CHECK,
    S_RETURN
  } state_e;

  // Saturating steps are evaluated in 32 bits so neither direction can wrap.
  function automatic logic [CNT_W-1:0] step_up(input logic [CNT_W-1:0] pw);
    logic [31:0] sum;
    sum = 32'(pw) + 32'(STEP);
    return (sum >= 32'(MAX_PULSE)) ? MAX_PW : CNT_W'(sum);
  endfunction

  function automatic logic [CNT_W-1:0] step_down(input logic [CNT_W-1:0] pw);
    return (32'(pw) <= 32'(MIN_PULSE) + 32'(STEP)) ? MIN_PW : pw - CNT_W'(STEP);
  endfunction

  // Shared state
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic              frame_tick;
  logic              start_q;
  logic              start_edge;
  logic              turns_ok;
  logic [NUM_CH-1:0] accept;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] done_q, done_d;

  // Per-channel state
  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  pw_q    [NUM_CH];
  logic [CNT_W-1:0]  pw_d    [NUM_CH];
  logic [WAIT_W-1:0] wait_q  [NUM_CH];
  logic [WAIT_W-1:0] wait_d  [NUM_CH];
  logic [TURN_W-1:0] turn_q  [NUM_CH];
  logic [TURN_W-1:0] turn_d  [NUM_CH];
  logic [TURN_W-1:0] turns_q [NUM_CH];
  logic [TURN_W-1:0] turns_d [NUM_CH];

  always_comb begin
    frame_d    = (frame_q == FRAME_LAST) ? '0 : frame_q + CNT_W'(1);
    frame_tick = (frame_q == '0);
  end

  // Start qualification: a channel accepts only if it is addressed, idle and not
  // being aborted; an edge that no channel accepts is reported on err.
  always_comb begin
    start_edge = bus.start & ~start_q;
    turns_ok   = (bus.num_turns != '0);
    accept     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i] = start_edge && turns_ok && (bus.ch_sel == CH_W'(i))
                  && !busy_q[i] && !bus.abort[i];
    end
    err_d = start_edge & ~(|accept);
  end

  // NOTE: every signal written here gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pwm_d  = '0;
    busy_d = '0;
    done_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      pw_d[i]    = pw_q[i];
      wait_d[i]  = wait_q[i];
      turn_d[i]  = turn_q[i];
      turns_d[i] = turns_q[i];

      if (bus.abort[i] && state_q[i] != S_IDLE && state_q[i] != S_RETURN) begin
        state_d[i] = S_RETURN;
      end else begin
        unique case (state_q[i])
          S_IDLE: begin
            pw_d[i] = MIN_PW;
            if (accept[i]) begin
              turns_d[i] = bus.num_turns;
              turn_d[i]  = '0;
              wait_d[i]  = '0;
              state_d[i] = S_PAUSE_LOW;
            end
          end
          S_PAUSE_LOW: begin
            pw_d[i] = MIN_PW;
            if (wait_q[i] == WAIT_LAST) begin
              wait_d[i]  = '0;
              state_d[i] = S_SWEEP_UP;
            end else begin
              wait_d[i] = wait_q[i] + WAIT_W'(1);
            end
          end
          S_SWEEP_UP: begin
            if (frame_tick) begin
              if (pw_q[i] >= MAX_PW) state_d[i] = S_PAUSE_HIGH;
              else                   pw_d[i]    = step_up(pw_q[i]);
            end
          end
          S_PAUSE_HIGH: begin
            pw_d[i] = MAX_PW;
            if (wait_q[i] == WAIT_LAST) begin
              wait_d[i]  = '0;
              state_d[i] = S_SWEEP_DOWN;
            end else begin
              wait_d[i] = wait_q[i] + WAIT_W'(1);
            end
          end
          S_SWEEP_DOWN: begin
            if (frame_tick) begin
              if (pw_q[i] <= MIN_PW) state_d[i] = S_CHECK;
              else                   pw_d[i]    = step_down(pw_q[i]);
            end
          end
          S_CHECK: begin
            if (({1'b0, turn_q[i]} + {{TURN_W{1'b0}}, 1'b1}) >= {1'b0, turns_q[i]}) begin
              state_d[i] = S_IDLE;
              done_d[i]  = 1'b1;
            end else begin
              turn_d[i]  = turn_q[i] + TURN_W'(1);
              wait_d[i]  = '0;
              state_d[i] = S_PAUSE_LOW;
            end
          end
          S_RETURN: begin
            if (frame_tick) begin
              if (pw_q[i] <= MIN_PW) state_d[i] = S_IDLE;
              else                   pw_d[i]    = step_down(pw_q[i]);
            end
          end
          default: state_d[i] = S_IDLE;
        endcase
      end

      busy_d[i] = (state_d[i] != S_IDLE);
      pwm_d[i]  = (frame_q < pw_q[i]);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      pwm_q   <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        pw_q[i]    <= MIN_PW;
        wait_q[i]  <= '0;
        turn_q[i]  <= '0;
        turns_q[i] <= '0;
      end
    end else begin
      frame_q <= frame_d;
      start_q <= bus.start;
      err_q   <= err_d;
      pwm_q   <= pwm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        pw_q[i]    <= pw_d[i];
        wait_q[i]  <= wait_d[i];
        turn_q[i]  <= turn_d[i];
        turns_q[i] <= turns_d[i];
      end
    end
  end

  assign bus.pwm_out = pwm_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_multi_servo_sweeper.sv
// Scoreboard bench for multi_servo_sweeper: stimulus queues expected PWM widths,
// done and err pulses; a negedge monitor measures the DUT and pops/compares.
module tb_multi_servo_sweeper;

  localparam int NUM_CH = 2;
  localparam int FR     = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multi_servo_sweeper_if #(.NUM_CH(NUM_CH), .TURN_W(4)) bus ();

  multi_servo_sweeper #(
    .NUM_CH(NUM_CH), .FRAME_CYC(FR), .MIN_PULSE(10), .MAX_PULSE(50),
    .STEP(15), .PAUSE_CYC(20), .TURN_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference frame position, used only to place stimulus at known phases.
  int tb_fc;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_fc <= 0;
    else     tb_fc <= (tb_fc == FR - 1) ? 0 : tb_fc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  int exp_w0[$];
  int exp_w1[$];
  int exp_d0[$];
  int exp_d1[$];
  int exp_err[$];
  int run0 = 0;
  int run1 = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int pending();
    return exp_w0.size() + exp_w1.size() + exp_d0.size() + exp_d1.size() + exp_err.size();
  endfunction

  // Monitor: high-run length per channel on each falling edge, plus pulse events.
  always @(negedge clk) begin
    if (rst) begin
      run0 = 0;
      run1 = 0;
    end else begin
      if (bus.pwm_out[0]) run0++;
      else if (run0 != 0) begin
        if (exp_w0.size() != 0) check("width_ch0", run0, exp_w0.pop_front());
        run0 = 0;
      end
      if (bus.pwm_out[1]) run1++;
      else if (run1 != 0) begin
        if (exp_w1.size() != 0) check("width_ch1", run1, exp_w1.pop_front());
        run1 = 0;
      end
      if (bus.done[0]) begin
        check("done_ch0_expected", (exp_d0.size() != 0) ? 1 : 0, 1);
        if (exp_d0.size() != 0) void'(exp_d0.pop_front());
      end
      if (bus.done[1]) begin
        check("done_ch1_expected", (exp_d1.size() != 0) ? 1 : 0, 1);
        if (exp_d1.size() != 0) void'(exp_d1.pop_front());
      end
      if (bus.err) begin
        check("err_expected", (exp_err.size() != 0) ? 1 : 0, 1);
        if (exp_err.size() != 0) void'(exp_err.pop_front());
      end
    end
  end

  task automatic push_w(input int ch, input int w);
    if (ch == 0) exp_w0.push_back(w);
    else         exp_w1.push_back(w);
  endtask

  // One full sweep seen from a start (or CHECK) aligned before the next tick.
  task automatic push_sweeps(input int ch, input int turns);
    int seq [8] = '{25, 40, 50, 50, 35, 20, 10, 10};
    for (int t = 0; t < turns; t++)
      for (int k = 0; k < 8; k++) push_w(ch, seq[k]);
  endtask

  task automatic wait_pos(input int p);
    int guard = 0;
    @(negedge clk);
    while (tb_fc != p && guard < 2 * FR) begin
      @(negedge clk);
      guard++;
    end
    if (tb_fc != p) check("wait_pos_timeout", tb_fc, p);
  endtask

  task automatic start_now(input int ch, input int turns);
    bus.ch_sel    = 1'(ch);
    bus.num_turns = 4'(turns);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, pending(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.ch_sel    = '0;
    bus.num_turns = '0;
    bus.abort     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pwm",  int'(bus.pwm_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err",  int'(bus.err), 0);
    rst = 1'b0;

    // 1: reset in the middle of a sweep
    start_now(0, 2);
    check("t1_busy_after_start", int'(bus.busy[0]), 1);
    repeat (150) @(negedge clk);
    check("t1_busy_mid", int'(bus.busy[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_pwm",  int'(bus.pwm_out), 0);
    check("t1_rst_busy", int'(bus.busy), 0);
    check("t1_rst_done", int'(bus.done), 0);
    check("t1_rst_err",  int'(bus.err), 0);
    repeat (2) @(negedge clk);
    push_w(0, 10); push_w(0, 10);
    push_w(1, 10); push_w(1, 10);
    rst = 1'b0;
    drain("t1_drain", 4 * FR);
    check("t1_busy_idle", int'(bus.busy), 0);

    // 2: single sweep on ch0
    wait_pos(20);
    push_sweeps(0, 1);
    exp_d0.push_back(1);
    start_now(0, 1);
    check("t2_busy_next", int'(bus.busy[0]), 1);
    drain("t2_drain", 12 * FR);
    check("t2_busy_end", int'(bus.busy[0]), 0);

    // 3+4: ch1 three sweeps with num_turns changed mid-job; rejected starts
    wait_pos(20);
    push_sweeps(1, 3);
    exp_d1.push_back(1);
    start_now(1, 3);
    bus.num_turns = 4'd1;
    check("t3_busy1", int'(bus.busy[1]), 1);
    wait_pos(50);
    exp_err.push_back(1);
    start_now(0, 0);
    check("t4_zero_turns_idle", int'(bus.busy[0]), 0);
    wait_pos(20);
    push_sweeps(0, 1);
    exp_d0.push_back(1);
    start_now(0, 1);
    check("t4_ch0_busy", int'(bus.busy[0]), 1);
    wait_pos(50);
    exp_err.push_back(1);
    start_now(0, 1);
    check("t4_ch0_still_busy", int'(bus.busy[0]), 1);
    wait_pos(60);
    exp_err.push_back(1);
    start_now(1, 2);
    check("t4_ch1_still_busy", int'(bus.busy[1]), 1);
    drain("t3_drain", 30 * FR);
    check("t3_busy_end", int'(bus.busy), 0);

    // 5: abort ch0 while sweeping up at pw = 40
    wait_pos(20);
    push_w(0, 25); push_w(0, 40); push_w(0, 25); push_w(0, 10); push_w(0, 10);
    start_now(0, 1);
    wait_pos(50);
    wait_pos(50);
    wait_pos(50);
    bus.abort[0] = 1'b1;
    repeat (5) @(negedge clk);
    bus.abort[0] = 1'b0;
    wait_pos(50);
    check("t5_busy_returning_a", int'(bus.busy[0]), 1);
    wait_pos(50);
    check("t5_busy_returning_b", int'(bus.busy[0]), 1);
    wait_pos(10);
    check("t5_busy_fell", int'(bus.busy[0]), 0);
    drain("t5_drain", 4 * FR);

    // 6: both channels, 37 cycles apart, plus same-cycle start+abort on ch1
    wait_pos(20);
    push_sweeps(0, 1);
    push_sweeps(1, 1);
    exp_d0.push_back(1);
    exp_d1.push_back(1);
    start_now(0, 1);
    wait_pos(40);
    exp_err.push_back(1);
    bus.abort[1] = 1'b1;
    start_now(1, 1);
    check("t6_abort_wins", int'(bus.busy[1]), 0);
    bus.abort[1] = 1'b0;
    wait_pos(57);
    start_now(1, 1);
    check("t6_ch1_busy", int'(bus.busy[1]), 1);
    check("t6_ch0_busy", int'(bus.busy[0]), 1);
    drain("t6_drain", 12 * FR);
    check("t6_busy_end", int'(bus.busy), 0);

    repeat (5) @(negedge clk);
    check("final_pending", pending(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
